tdm_demux: RTL and testbench

Time-division demultiplexer: receiving end of the serial TDM link that our mux datapath drives. Accepts a 1-bit serial stream with a frame-sync marker, acquires frame alignment, deserializes each slot MSB-first, and routes the completed word to the matching output channel with a one-cycle valid pulse. It sits between the serial link input and the per-channel consumers.

---
 rtl/tdm_pkg.sv | 24 ++
 rtl/tdm_slot_shift.sv | 44 ++++
 rtl/tdm_demux.sv | 110 +++++++++++
 tb/tb_tdm_demux.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link: frame geometry defaults and the
// demux frame-alignment state encoding.
package tdm_pkg;

    localparam int TDM_NUM_CH = 4;
    localparam int TDM_SLOT_W = 8;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } tdm_state_e;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_w(input int n);
        int w;
        if (n > 32'sd1) begin
            w = $clog2(n);
        end else begin
            w = 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/tdm_slot_shift.sv
// Slot deserializer: MSB-first shift register with its bit counter; flags
// the bit that completes a word and presents the assembled word alongside it.
module tdm_slot_shift
    import tdm_pkg::*;
#(
    parameter int SLOT_W = TDM_SLOT_W,
    localparam int BW    = cnt_w(SLOT_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              load,
    input  logic              shift,
    output logic [BW-1:0]     bit_cnt,
    output logic [SLOT_W-1:0] word,
    output logic              word_done
);

    localparam int SW1                 = SLOT_W - 32'sd1;
    localparam logic [BW-1:0] BIT_LAST = BW'(SLOT_W - 32'sd1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(32'sd1);

    logic [SW1-1:0] shreg_r;
    logic [BW-1:0]  bit_cnt_r;

    assign word      = {shreg_r, din};
    assign word_done = shift & (bit_cnt_r == BIT_LAST);
    assign bit_cnt   = bit_cnt_r;

    // Load starts a fresh word with this bit as MSB; shift appends one bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r   <= {SW1{1'b0}};
            bit_cnt_r <= {BW{1'b0}};
        end else if (load) begin
            shreg_r   <= SW1'(din);
            bit_cnt_r <= BIT_ONE;
        end else if (shift) begin
            shreg_r   <= word[SW1-1:0];
            bit_cnt_r <= word_done ? {BW{1'b0}} : (bit_cnt_r + BIT_ONE);
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// TDM receiver: hunts for frame sync, tracks slot position with a flywheel
// over missing syncs, and routes each completed slot word to its channel.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int NUM_CH   = TDM_NUM_CH,
    parameter int SLOT_W   = TDM_SLOT_W,
    parameter int MISS_MAX = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     din,
    input  logic                     din_en,
    input  logic                     frame_sync,
    output logic [NUM_CH*SLOT_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_valid,
    output logic                     locked,
    output logic                     sync_err
);

    localparam int BW = cnt_w(SLOT_W);
    localparam int CW = cnt_w(NUM_CH);
    localparam int MW = cnt_w(MISS_MAX + 32'sd1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(NUM_CH - 32'sd1);
    localparam logic [CW-1:0] SLOT_ONE  = CW'(32'sd1);
    localparam logic [MW-1:0] MISS_LAST = MW'(MISS_MAX);
    localparam logic [MW-1:0] MISS_ONE  = MW'(32'sd1);

    tdm_state_e        state_r;
    logic [CW-1:0]     slot_cnt_r;
    logic [MW-1:0]     miss_cnt_r;
    logic [BW-1:0]     bit_cnt_s;
    logic [SLOT_W-1:0] word_s;
    logic              word_done_s;
    logic              at_exp_s;
    logic              load_s;
    logic              shift_s;
    logic              misalign_s;
    logic              lose_s;

    assign at_exp_s = (slot_cnt_r == {CW{1'b0}}) && (bit_cnt_s == {BW{1'b0}});

    tdm_slot_shift #(.SLOT_W(SLOT_W)) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .load      (load_s),
        .shift     (shift_s),
        .bit_cnt   (bit_cnt_s),
        .word      (word_s),
        .word_done (word_done_s)
    );

    // Classify the current strobe: acquire/realign, drop lock, or plain decode.
    always_comb begin
        load_s     = 1'b0;
        shift_s    = 1'b0;
        misalign_s = 1'b0;
        lose_s     = 1'b0;
        if (!din_en) begin
            load_s = 1'b0;
        end else if (state_r == ST_HUNT) begin
            load_s = frame_sync;
        end else if (frame_sync && !at_exp_s) begin
            misalign_s = 1'b1;
            load_s     = 1'b1;
        end else if (at_exp_s && !frame_sync && (miss_cnt_r == MISS_LAST)) begin
            lose_s = 1'b1;
        end else begin
            shift_s = 1'b1;
        end
    end

    // Frame FSM, slot/miss tracking and registered output routing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_HUNT;
            slot_cnt_r <= {CW{1'b0}};
            miss_cnt_r <= {MW{1'b0}};
            ch_data    <= {(NUM_CH*SLOT_W){1'b0}};
            ch_valid   <= {NUM_CH{1'b0}};
            locked     <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            ch_valid <= {NUM_CH{1'b0}};
            sync_err <= misalign_s | lose_s;
            if (load_s) begin
                state_r    <= ST_LOCKED;
                locked     <= 1'b1;
                slot_cnt_r <= {CW{1'b0}};
                miss_cnt_r <= {MW{1'b0}};
            end else if (lose_s) begin
                state_r    <= ST_HUNT;
                locked     <= 1'b0;
                miss_cnt_r <= {MW{1'b0}};
            end else if (shift_s) begin
                // Flywheel: an absent sync at frame start is counted, not fatal.
                if (at_exp_s) begin
                    miss_cnt_r <= frame_sync ? {MW{1'b0}} : (miss_cnt_r + MISS_ONE);
                end
                if (word_done_s) begin
                    ch_data[slot_cnt_r*SLOT_W +: SLOT_W] <= word_s;
                    ch_valid[slot_cnt_r]                 <= 1'b1;
                    slot_cnt_r <= (slot_cnt_r == SLOT_LAST) ? {CW{1'b0}} : (slot_cnt_r + SLOT_ONE);
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// Randomized bench for tdm_demux, checked every cycle against a frame-position
// reference model.
module tb_tdm_demux;

    localparam int NUM_CH   = 4;
    localparam int SLOT_W   = 8;
    localparam int MISS_MAX = 2;
    localparam int FRAME    = NUM_CH * SLOT_W;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din;
    logic        din_en;
    logic        frame_sync;
    logic [31:0] ch_data;
    logic [3:0]  ch_valid;
    logic        locked;
    logic        sync_err;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: lock flag, bit position within the frame, misses.
    bit         m_locked;
    int         m_pos;
    int         m_miss;
    logic [7:0] m_acc;
    logic [7:0] m_data [NUM_CH];
    logic [3:0] m_valid;
    logic       m_err;

    // Free-running clock.
    always #5 clk = ~clk;

    tdm_demux #(.NUM_CH(NUM_CH), .SLOT_W(SLOT_W), .MISS_MAX(MISS_MAX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_en     (din_en),
        .frame_sync (frame_sync),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_pos    = 0;
        m_miss   = 0;
        m_acc    = 8'h00;
        m_valid  = 4'b0000;
        m_err    = 1'b0;
        for (int k = 0; k < NUM_CH; k++) m_data[k] = 8'h00;
    endtask

    task automatic model_bit(input logic d, input logic fs);
        m_valid = 4'b0000;
        m_err   = 1'b0;
        if (!m_locked) begin
            if (fs) begin
                m_locked = 1'b1;
                m_pos    = 1;
                m_acc    = {7'b0, d};
                m_miss   = 0;
            end
        end else if (fs && m_pos != 0) begin
            m_err  = 1'b1;
            m_pos  = 1;
            m_acc  = {7'b0, d};
            m_miss = 0;
        end else if (m_pos == 0 && !fs && m_miss == MISS_MAX) begin
            m_err    = 1'b1;
            m_locked = 1'b0;
        end else begin
            if (m_pos == 0) m_miss = fs ? 0 : m_miss + 1;
            m_acc = {m_acc[6:0], d};
            if (m_pos % SLOT_W == SLOT_W - 1) begin
                m_data[m_pos / SLOT_W]  = m_acc;
                m_valid[m_pos / SLOT_W] = 1'b1;
            end
            m_pos = (m_pos + 1) % FRAME;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] e;
        for (int k = 0; k < NUM_CH; k++) e[k*SLOT_W +: SLOT_W] = m_data[k];
        chk({tag, ".data"},   ch_data,  e);
        chk({tag, ".valid"},  ch_valid, m_valid);
        chk({tag, ".locked"}, locked,   m_locked);
        chk({tag, ".err"},    sync_err, m_err);
    endtask

    task automatic step(input logic en, input logic d, input logic fs);
        din_en     = en;
        din        = d;
        frame_sync = fs;
        if (en) begin
            model_bit(d, fs);
        end else begin
            m_valid = 4'b0000;
            m_err   = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outputs("step");
    endtask

    task automatic send_word(input logic [7:0] w, input logic sync, input int gap);
        for (int i = SLOT_W - 1; i >= 0; i--) begin
            step(1'b1, w[i], sync && (i == SLOT_W - 1));
            for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic send_frame(input logic [31:0] f, input logic sync, input int gap);
        for (int k = 0; k < NUM_CH; k++) send_word(f[k*SLOT_W +: SLOT_W], sync && (k == 0), gap);
    endtask

    // Reset asserted mid-cycle so its asynchronous effect is visible at once.
    task automatic do_reset();
        din_en     = 1'b0;
        din        = 1'b0;
        frame_sync = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst");
        @(posedge clk);
        #1;
        check_outputs("rst_hold");
        rst_n = 1'b1;
    endtask

    initial begin
        logic en_r;
        logic fs_r;
        rst_n      = 1'b1;
        din_en     = 1'b0;
        din        = 1'b0;
        frame_sync = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom), 1'b0);
        chk("hunt.locked", locked, 1'b0);
        chk("hunt.data", ch_data, 32'h0000_0000);

        send_frame(32'h01FF3CA5, 1'b1, 0);
        chk("acq.locked", locked, 1'b1);
        chk("acq.data", ch_data, 32'h01FF3CA5);

        repeat (2) send_frame($urandom, 1'b0, 0);
        step(1'b1, 1'($urandom), 1'b0);
        chk("fly.err", sync_err, 1'b1);
        chk("fly.locked", locked, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 1'($urandom), 1'b0);

        send_word(8'h11, 1'b1, 0);
        send_word(8'h22, 1'b0, 0);
        send_word(8'h33, 1'b0, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'b0);
        send_word(8'h5A, 1'b1, 0);
        chk("mis.ch0", ch_data[7:0], 8'h5A);
        chk("mis.valid", ch_valid, 4'b0001);
        for (int k = 1; k < NUM_CH; k++) send_word(8'($urandom), 1'b0, 0);

        do_reset();
        send_frame(32'h01FF3CA5, 1'b1, 2);
        chk("gap.data", ch_data, 32'h01FF3CA5);
        send_word(8'hA5, 1'b1, 2);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'($urandom), 1'b0);
            step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        do_reset();
        chk("midrst.data", ch_data, 32'h0000_0000);
        for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom), 1'b0);
        chk("midrst.hunt", locked, 1'b0);
        send_frame(32'h01FF3CA5, 1'b1, 2);

        for (int i = 0; i < 1500; i++) begin
            en_r = ($urandom_range(0, 3) != 0);
            fs_r = ((m_pos == 0) && ($urandom_range(0, 4) != 0)) || ($urandom_range(0, 70) == 0);
            step(en_r, 1'($urandom), fs_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
